// File: rtl/flit_source_pkg.sv
// Shared definitions for the flit source: FSM encoding, packet-format
// constants, the clogb helper and the pseudo-random generator used to
// make injection and packet-length decisions.
package flit_source_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int PKT_CNT_W  = 32;     // packet counter field width
  localparam int SRC_DIM_W  = 2;      // width of each source coordinate field
  localparam int RATE_SCALE = 10000;  // injection probability denominator
  localparam int DRAW_W     = 16;     // random bits consumed per uniform draw

  // Ceiling log2: clogb(1)=0, clogb(8)=3, clogb(9)=4.
  function automatic int clogb(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // xorshift32 step; never maps a non-zero state to zero.
  function automatic logic [31:0] rng_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Derive a non-zero generator state from the integer seed.
  function automatic logic [31:0] rng_seed(input int s);
    logic [31:0] y;
    y = 32'(s) ^ 32'h9E37_79B9;
    if (y == '0) y = 32'h0000_0001;
    return y;
  endfunction

endpackage

// File: rtl/flit_source_vc_credit.sv
// Credit counter for one virtual channel.
//   clk, reset : clock, asynchronous active-low reset
//   send_i     : a flit is being sent on this VC this cycle
//   credit_i   : a credit for this VC arrives this cycle
//   avail_o    : counter is non-zero
//   error_o    : sticky overflow/underflow flag
module flit_source_vc_credit #(
  parameter int credits_max  = 8,
  parameter int credit_width = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic send_i,
  input  logic credit_i,
  output logic avail_o,
  output logic error_o
);

  localparam logic [credit_width-1:0] full_count = credit_width'(credits_max);

  logic [credit_width-1:0] count_q, count_d;
  logic                    error_q, error_d;

  always_comb begin
    count_d = count_q;
    error_d = error_q;
    // Sending at zero is a guard that should never trip; a lone credit at
    // the full count means the receiver returned more than it was given.
    if (send_i && count_q == '0) error_d = 1'b1;
    if (credit_i && !send_i && count_q == full_count) error_d = 1'b1;
    // Send and credit together cancel out.
    if (send_i && !credit_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end else if (credit_i && !send_i && count_q != full_count) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= full_count;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign avail_o = (count_q != '0);
  assign error_o = error_q;

endmodule

// File: rtl/flit_source.sv
// Random packet source for a NoC input port with per-VC credit flow control.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   inject_en : new packets may start while high
//   flow_ctrl : {credit vc index, credit valid}
//   channel   : registered {link active, flit valid, vc, head, data}
//   error     : sticky credit-protocol error
module flit_source
  import flit_source_pkg::*;
#(
  parameter int initial_seed       = 0,
  parameter int injection_rate     = 10000,
  parameter int buffer_size        = 64,
  parameter int num_vcs            = 8,
  parameter int max_payload_length = 4,
  parameter int min_payload_length = 1,
  parameter int flit_data_width    = 64,
  parameter int enable_link_pm     = 1,
  localparam int vc_idx_width      = clogb(num_vcs),
  localparam int link_ctrl_width   = (enable_link_pm != 0) ? 1 : 0,
  localparam int channel_width     = link_ctrl_width + 1 + vc_idx_width + 1 + flit_data_width
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inject_en,
  input  logic [vc_idx_width:0]    flow_ctrl,
  output logic [channel_width-1:0] channel,
  output logic                     error
);

  localparam int credits_per_vc       = buffer_size / num_vcs;
  localparam int credit_width         = clogb(credits_per_vc + 1);
  localparam int len_span             = max_payload_length - min_payload_length + 1;
  localparam int payload_length_width = clogb(len_span);
  localparam int len_width_raw        = clogb(max_payload_length + 1);
  localparam int len_width            = (len_width_raw > 0) ? len_width_raw : 1;
  localparam int flit_width           = 1 + vc_idx_width + 1 + flit_data_width;
  localparam logic [SRC_DIM_W-1:0] src_dim1 = 2'((initial_seed - 9) / 3);
  localparam logic [SRC_DIM_W-1:0] src_dim2 = 2'((initial_seed - 9) % 3);
  localparam logic [flit_data_width-1:0] len_field_mask =
    flit_data_width'((64'd1 << payload_length_width) - 64'd1);

  state_e                  state_q, state_d;
  logic [vc_idx_width-1:0] vc_q, vc_d;
  logic [vc_idx_width-1:0] rr_q, rr_d;
  logic [vc_idx_width-1:0] pick_vc;
  logic                    pick_found;
  int                      cand_idx;
  logic [len_width-1:0]    len_q, len_d;
  logic [len_width-1:0]    flit_idx_q, flit_idx_d;
  logic [len_width-1:0]    len_draw, len_off;
  logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [31:0]             rng_q, rng_d;
  logic [31:0]             rate_draw, len_scaled;
  logic [flit_width-1:0]   flit_q, flit_d;
  logic                    link_d;
  logic [flit_data_width-1:0] flit_data;
  logic [num_vcs-1:0]      vc_avail, vc_send, vc_credit, vc_error;

  // Uniform draws by scaling 16 random bits: 0..9999 and min..max.
  assign rate_draw  = ({16'd0, rng_q[15:0]} * 32'(RATE_SCALE)) >> DRAW_W;
  assign len_scaled = ({16'd0, rng_q[31:16]} * 32'(len_span)) >> DRAW_W;
  assign len_draw   = len_width'(32'(min_payload_length) + len_scaled);

  // Round-robin search starting at the pointer itself: the pointer stays on
  // the winning VC, so one VC keeps taking packets until it runs dry.
  always_comb begin
    pick_found = 1'b0;
    pick_vc    = rr_q;
    cand_idx   = 0;
    for (int k = 0; k < num_vcs; k++) begin
      cand_idx = (int'(rr_q) + k) % num_vcs;
      if (!pick_found && vc_avail[cand_idx]) begin
        pick_found = 1'b1;
        pick_vc    = vc_idx_width'(cand_idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    vc_d       = vc_q;
    rr_d       = rr_q;
    len_d      = len_q;
    flit_idx_d = flit_idx_q;
    pkt_cnt_d  = pkt_cnt_q;
    rng_d      = rng_next(rng_q);
    flit_d     = '0;
    link_d     = 1'b0;
    vc_send    = '0;

    len_off   = len_q - len_width'(min_payload_length);
    flit_data = '0;
    flit_data[flit_data_width-5 -: PKT_CNT_W] = pkt_cnt_q;
    flit_data[flit_data_width-3 -: SRC_DIM_W] = src_dim1;
    flit_data[flit_data_width-1 -: SRC_DIM_W] = src_dim2;
    if (flit_idx_q == '0) begin
      flit_data = flit_data | (flit_data_width'(len_off) & len_field_mask);
    end

    case (state_q)
      ST_IDLE: begin
        if (inject_en && (rate_draw < 32'(injection_rate)) && pick_found) begin
          state_d    = ST_SEND;
          vc_d       = pick_vc;
          rr_d       = pick_vc;
          len_d      = len_draw;
          flit_idx_d = '0;
        end
      end
      ST_SEND: begin
        link_d = 1'b1;
        // Stall with valid low whenever the latched VC has no credit.
        if (vc_avail[vc_q]) begin
          vc_send[vc_q] = 1'b1;
          flit_d = {1'b1, vc_q, (flit_idx_q == '0), flit_data};
          if (flit_idx_q == len_q) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end else begin
            flit_idx_d = flit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      vc_q       <= '0;
      rr_q       <= '0;
      len_q      <= '0;
      flit_idx_q <= '0;
      pkt_cnt_q  <= '0;
      rng_q      <= rng_seed(initial_seed);
      flit_q     <= '0;
    end else begin
      state_q    <= state_d;
      vc_q       <= vc_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      flit_idx_q <= flit_idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      rng_q      <= rng_d;
      flit_q     <= flit_d;
    end
  end

  generate
    if (enable_link_pm != 0) begin : g_link
      logic link_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) link_q <= 1'b0;
        else        link_q <= link_d;
      end
      assign channel = {link_q, flit_q};
    end else begin : g_no_link
      assign channel = flit_q;
    end
  endgenerate

  for (genvar gi = 0; gi < num_vcs; gi++) begin : g_vc
    assign vc_credit[gi] = flow_ctrl[0] && (flow_ctrl[vc_idx_width:1] == vc_idx_width'(gi));
    flit_source_vc_credit #(
      .credits_max (credits_per_vc),
      .credit_width(credit_width)
    ) u_credit (
      .clk     (clk),
      .reset   (reset),
      .send_i  (vc_send[gi]),
      .credit_i(vc_credit[gi]),
      .avail_o (vc_avail[gi]),
      .error_o (vc_error[gi])
    );
  end

  assign error = |vc_error;

endmodule

// File: tb/tb_flit_source.sv
// Self-checking bench for flit_source with a packet-level reference model.
module tb_flit_source;
  localparam int NV   = 8;
  localparam int CRED = 8;
  localparam int LEN  = 2;
  localparam int W    = 64;
  localparam int VW   = 3;
  localparam int SEED = 13;
  localparam int CH_W = 1 + 1 + VW + 1 + W;
  localparam int DIM1 = (SEED - 9) / 3;
  localparam int DIM2 = (SEED - 9) % 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            inject_en;
  logic [VW:0]     flow_ctrl;
  logic [CH_W-1:0] channel;
  logic            error;

  always #5 clk = ~clk;

  flit_source #(
    .initial_seed(SEED), .injection_rate(10000), .buffer_size(64), .num_vcs(NV),
    .max_payload_length(LEN), .min_payload_length(LEN), .flit_data_width(W),
    .enable_link_pm(1)
  ) dut (
    .clk(clk), .reset(reset), .inject_en(inject_en), .flow_ctrl(flow_ctrl),
    .channel(channel), .error(error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: credits per VC, current packet, counters.
  int              m_cred [NV];
  bit              m_busy;
  int              m_vc, m_sent, m_rr, exp_flits;
  logic [31:0]     m_pkt;
  bit              m_err;
  logic [CH_W-1:0] exp_channel;
  logic            exp_error;

  function automatic logic [W-1:0] mk_data(input logic [31:0] pc);
    logic [W-1:0] d;
    d = '0;
    d = d | (W'(pc) << (W - 36));
    d = d | (W'(DIM1) << (W - 4));
    d = d | (W'(DIM2) << (W - 2));
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_cred[i] = CRED;
    m_busy = 0; m_vc = 0; m_sent = 0; m_rr = 0; m_pkt = '0; m_err = 0;
    exp_flits = 0; exp_channel = '0; exp_error = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present this cycle.
  task automatic model_cycle();
    bit send, link, head;
    int sv, fv, pre, v;
    logic [W-1:0] d;
    send = 0; head = 0; sv = 0; d = '0;
    link = m_busy;
    fv  = int'(flow_ctrl[VW:1]);
    pre = m_cred[fv];
    if (m_busy) begin
      if (m_cred[m_vc] > 0) begin
        send = 1; sv = m_vc; head = (m_sent == 0);
        d = mk_data(m_pkt);
        m_sent++;
        if (m_sent == 1 + LEN) begin
          m_busy = 0;
          m_pkt  = m_pkt + 1;
        end
      end
    end else if (inject_en) begin
      for (int k = 0; k < NV; k++) begin
        v = (m_rr + k) % NV;
        if (m_cred[v] > 0) begin
          m_busy = 1; m_vc = v; m_rr = v; m_sent = 0;
          break;
        end
      end
    end
    if (send) begin
      m_cred[sv]--;
      exp_flits++;
    end
    if (flow_ctrl[0]) begin
      if (send && sv == fv) m_cred[fv]++;
      else if (pre >= CRED) m_err = 1;
      else m_cred[fv]++;
    end
    exp_channel = {link, send, VW'(sv), head, d};
    exp_error   = m_err;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    if (channel[W+1+VW])
      $display("[TB] flit vc=%0d head=%0b pkt=%0d link=%0b", channel[W+1 +: VW],
               channel[W], channel[W-5 -: 32], channel[CH_W-1]);
  endtask

  task automatic apply_reset();
    reset = 1'b0; inject_en = 1'b0; flow_ctrl = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; inject_en = 1'b0; flow_ctrl = '0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (channel !== '0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: channel=%h error=%b, expected 0/0", channel, error);
    end
    inject_en = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (channel !== '0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: channel=%h error=%b, expected 0/0", channel, error);
    end
    inject_en = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_first_packets();
    int vc0_flits, first_head_vc;
    apply_reset();
    inject_en = 1'b1;
    vc0_flits = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      tests_run++;
      if (channel !== exp_channel || error !== exp_error) begin
        tests_failed++;
        $display("FAIL first_packets c%0d: channel=%h error=%b, expected %h/%b",
                 c, channel, error, exp_channel, exp_error);
      end
      if (channel[W+1+VW] && channel[W+1 +: VW] == 0) vc0_flits++;
    end
    tests_run++;
    if (vc0_flits !== 8) begin
      tests_failed++;
      $display("FAIL vc0_flit_count: got %0d, expected 8", vc0_flits);
    end
    tests_run++;
    if (channel[W+1+VW] !== 1'b0 || channel[CH_W-1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_state: valid=%b link=%b, expected valid=0 link=1",
               channel[W+1+VW], channel[CH_W-1]);
    end
    flow_ctrl = {VW'(0), 1'b1};
    step();
    flow_ctrl = '0;
    first_head_vc = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      tests_run++;
      if (channel !== exp_channel || error !== exp_error) begin
        tests_failed++;
        $display("FAIL resume c%0d: channel=%h error=%b, expected %h/%b",
                 c, channel, error, exp_channel, exp_error);
      end
      if (first_head_vc < 0 && channel[W+1+VW] && channel[W]) first_head_vc = int'(channel[W+1 +: VW]);
    end
    tests_run++;
    if (first_head_vc !== 1) begin
      tests_failed++;
      $display("FAIL next_packet_vc: got %0d, expected 1", first_head_vc);
    end
  endtask

  task automatic test_simul_credit();
    int obs_flits, other_vc;
    apply_reset();
    inject_en = 1'b1;
    obs_flits = 0; other_vc = 0;
    for (int c = 0; c < 60; c++) begin
      // Return a credit in exactly the cycles where a flit is sent.
      if (m_busy && m_cred[m_vc] > 0) flow_ctrl = {VW'(m_vc), 1'b1};
      else flow_ctrl = '0;
      step();
      tests_run++;
      if (channel !== exp_channel || error !== exp_error) begin
        tests_failed++;
        $display("FAIL simul_credit c%0d: channel=%h error=%b, expected %h/%b",
                 c, channel, error, exp_channel, exp_error);
      end
      if (channel[W+1+VW]) begin
        obs_flits++;
        if (channel[W+1 +: VW] != 0) other_vc++;
      end
    end
    flow_ctrl = '0;
    tests_run++;
    if (obs_flits !== exp_flits || other_vc !== 0) begin
      tests_failed++;
      $display("FAIL simul_flits: got %0d flits (%0d off VC0), expected %0d on VC0",
               obs_flits, other_vc, exp_flits);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    step();
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_pre: error=%b, expected 0", error);
    end
    flow_ctrl = {VW'(5), 1'b1};
    step();
    flow_ctrl = '0;
    tests_run++;
    if (error !== 1'b1 || error !== exp_error) begin
      tests_failed++;
      $display("FAIL overflow_set: error=%b, expected 1", error);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++;
      if (error !== exp_error || channel !== exp_channel) begin
        tests_failed++;
        $display("FAIL overflow_hold c%0d: error=%b channel=%h, expected %b/%h",
                 c, error, channel, exp_error, exp_channel);
      end
    end
  endtask

  task automatic test_src_fields();
    int heads;
    apply_reset();
    inject_en = 1'b1;
    heads = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (channel[W+1+VW]) begin
        tests_run++;
        if (int'(channel[W-3 -: 2]) !== DIM1 || int'(channel[W-1 -: 2]) !== DIM2) begin
          tests_failed++;
          $display("FAIL src_dims c%0d: dim1=%0d dim2=%0d, expected %0d/%0d",
                   c, channel[W-3 -: 2], channel[W-1 -: 2], DIM1, DIM2);
        end
        if (channel[W]) begin
          tests_run++;
          if (int'(channel[W-5 -: 32]) !== heads) begin
            tests_failed++;
            $display("FAIL head_pkt_cnt c%0d: got %0d, expected %0d", c, channel[W-5 -: 32], heads);
          end
          heads++;
        end
      end
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    inject_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      tests_run++;
      if (channel !== exp_channel) begin
        tests_failed++;
        $display("FAIL starve_run c%0d: channel=%h, expected %h", c, channel, exp_channel);
      end
      if (c >= 12 && channel[W+1+VW] !== 1'b0) begin
        tests_failed++;
        $display("FAIL starve_valid c%0d: valid=%b, expected 0", c, channel[W+1+VW]);
      end
    end
    flow_ctrl = {VW'(0), 1'b1};
    step();
    flow_ctrl = '0;
    tests_run++;
    if (channel[W+1+VW] !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_credit_plus1: valid=%b, expected 0", channel[W+1+VW]);
    end
    step();
    tests_run++;
    if (channel[W+1+VW] !== 1'b1 || channel[W] !== 1'b0 || channel !== exp_channel) begin
      tests_failed++;
      $display("FAIL starve_credit_plus2: channel=%h, expected %h", channel, exp_channel);
    end
  endtask

  task automatic test_reset_mid_packet();
    int first_pkt;
    bit first_head, seen;
    apply_reset();
    inject_en = 1'b1;
    for (int c = 0; c < 6; c++) step();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (channel !== '0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL midpkt_reset: channel=%h error=%b, expected 0/0", channel, error);
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    seen = 0; first_head = 0; first_pkt = -1;
    for (int c = 0; c < 6; c++) begin
      step();
      tests_run++;
      if (channel !== exp_channel) begin
        tests_failed++;
        $display("FAIL midpkt_after c%0d: channel=%h, expected %h", c, channel, exp_channel);
      end
      if (!seen && channel[W+1+VW]) begin
        seen = 1; first_head = channel[W]; first_pkt = int'(channel[W-5 -: 32]);
      end
    end
    tests_run++;
    if (!seen || first_head !== 1'b1 || first_pkt !== 0) begin
      tests_failed++;
      $display("FAIL midpkt_first_flit: seen=%b head=%b pkt=%0d, expected 1/1/0",
               seen, first_head, first_pkt);
    end
  endtask

  task automatic test_random();
    int v;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      inject_en = ($urandom_range(0, 3) != 0);
      v = $urandom_range(0, NV - 1);
      if ($urandom_range(0, 1) == 1 && m_cred[v] < CRED) flow_ctrl = {VW'(v), 1'b1};
      else flow_ctrl = '0;
      step();
      tests_run++;
      if (channel !== exp_channel || error !== exp_error) begin
        tests_failed++;
        $display("FAIL random c%0d: channel=%h error=%b, expected %h/%b",
                 c, channel, error, exp_channel, exp_error);
      end
    end
    inject_en = 1'b0;
    flow_ctrl = '0;
  endtask

  initial begin
    test_reset();
    test_first_packets();
    test_simul_credit();
    test_overflow();
    test_src_fields();
    test_starvation();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
